// File: rtl/pkg_defines.sv
// Rename-stage shared definitions: default tag width, pool size and the tag type.
package pkg_defines;
    localparam int TAG_WIDTH = 5;
    localparam int TAG_COUNT = 32;

    typedef logic [TAG_WIDTH-1:0] tag_t;
endpackage

// File: rtl/ren_tag_pool_if.sv
// Renamer <-> tag pool connection. The o_error line exists only when
// REN_TAG_POOL_CHECK_EN is defined.
interface ren_tag_pool_if #(
    parameter int TAG_WIDTH = pkg_defines::TAG_WIDTH
);
    logic [1:0]                o_ren_capacity;
    logic [1:0]                i_alloc_req;
    logic [1:0][TAG_WIDTH-1:0] o_alloc_tag;
    logic                      o_alloc_ok;
    logic [1:0]                i_commit;
    logic [1:0]                i_free_valid;
    logic [1:0][TAG_WIDTH-1:0] i_free_tag;
    logic                      i_flush;
    logic                      o_empty;
    logic                      o_full;
`ifdef REN_TAG_POOL_CHECK_EN
    logic                      o_error;

    modport master (
        output i_alloc_req, i_commit, i_free_valid, i_free_tag, i_flush,
        input  o_ren_capacity, o_alloc_tag, o_alloc_ok, o_empty, o_full, o_error
    );
    modport slave (
        input  i_alloc_req, i_commit, i_free_valid, i_free_tag, i_flush,
        output o_ren_capacity, o_alloc_tag, o_alloc_ok, o_empty, o_full, o_error
    );
`else
    modport master (
        output i_alloc_req, i_commit, i_free_valid, i_free_tag, i_flush,
        input  o_ren_capacity, o_alloc_tag, o_alloc_ok, o_empty, o_full
    );
    modport slave (
        input  i_alloc_req, i_commit, i_free_valid, i_free_tag, i_flush,
        output o_ren_capacity, o_alloc_tag, o_alloc_ok, o_empty, o_full
    );
`endif
endinterface

// File: rtl/ren_tag_pool.sv
// Rename tag free list: circular list with speculative head, committed head and tail.
// Defining REN_TAG_POOL_CHECK_EN adds ownership tracking and a sticky o_error.
module ren_tag_pool #(
    parameter int TAG_WIDTH = pkg_defines::TAG_WIDTH,
    parameter int TAG_COUNT = pkg_defines::TAG_COUNT
) (
    input  logic          i_clock,
    input  logic          i_reset,
    ren_tag_pool_if.slave bus
);
    localparam int PTR_W = $clog2(TAG_COUNT);
    localparam int CNT_W = TAG_WIDTH + 1;

    typedef logic [TAG_WIDTH-1:0] tag_lt;
    typedef logic [PTR_W-1:0]     ptr_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    tag_lt      list_reg [TAG_COUNT];
    ptr_t       spec_head_reg, spec_head_next;
    ptr_t       commit_head_reg, commit_head_next;
    ptr_t       tail_reg, tail_next;
    cnt_t       free_count_reg, free_count_next;
    cnt_t       spec_occ_reg, spec_occ_next;    // granted but not yet committed
    logic [1:0] capacity_reg;
    logic       empty_reg;
    logic       full_reg;

    logic [1:0] n_req, n_grant, n_commit, n_free;
    logic [1:0] free_acc;
    logic       alloc_ok;
    ptr_t       head_p1, wr0_ptr, wr1_ptr;
    cnt_t       uncommitted_left;

    assign n_req    = {1'b0, bus.i_alloc_req[0]} + {1'b0, bus.i_alloc_req[1]};
    assign n_commit = {1'b0, bus.i_commit[0]} + {1'b0, bus.i_commit[1]};
    assign n_free   = {1'b0, free_acc[0]} + {1'b0, free_acc[1]};
    assign alloc_ok = (cnt_t'(n_req) <= free_count_reg) && !bus.i_flush;
    assign n_grant  = alloc_ok ? n_req : 2'd0;

    assign head_p1 = spec_head_reg + ptr_t'(1);
    assign wr0_ptr = tail_reg;
    assign wr1_ptr = tail_reg + ptr_t'(free_acc[0]);

    assign bus.o_alloc_ok     = alloc_ok;
    assign bus.o_alloc_tag[0] = list_reg[spec_head_reg];
    // A lone slot-1 request takes the head entry rather than the one behind it
    assign bus.o_alloc_tag[1] = (bus.i_alloc_req == 2'b10) ? list_reg[spec_head_reg]
                                                          : list_reg[head_p1];
    assign bus.o_ren_capacity = capacity_reg;
    assign bus.o_empty        = empty_reg;
    assign bus.o_full         = full_reg;

    always_comb begin
        commit_head_next = commit_head_reg + ptr_t'(n_commit);
        uncommitted_left = spec_occ_reg - cnt_t'(n_commit);
        tail_next        = tail_reg + ptr_t'(n_free);
        if (bus.i_flush) begin
            // Uncommitted allocations return to the front of the free region
            spec_head_next  = commit_head_next;
            spec_occ_next   = '0;
            free_count_next = free_count_reg + cnt_t'(n_free) + uncommitted_left;
        end else begin
            spec_head_next  = spec_head_reg + ptr_t'(n_grant);
            spec_occ_next   = uncommitted_left + cnt_t'(n_grant);
            free_count_next = free_count_reg + cnt_t'(n_free) - cnt_t'(n_grant);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            spec_head_reg   <= '0;
            commit_head_reg <= '0;
            tail_reg        <= '0;
            free_count_reg  <= cnt_t'(TAG_COUNT);
            spec_occ_reg    <= '0;
            capacity_reg    <= (TAG_COUNT >= 2) ? 2'd2 : 2'(TAG_COUNT);
            empty_reg       <= 1'b0;
            full_reg        <= 1'b1;
        end else begin
            spec_head_reg   <= spec_head_next;
            commit_head_reg <= commit_head_next;
            tail_reg        <= tail_next;
            free_count_reg  <= free_count_next;
            spec_occ_reg    <= spec_occ_next;
            capacity_reg    <= (free_count_next >= cnt_t'(2)) ? 2'd2 : free_count_next[1:0];
            empty_reg       <= (free_count_next == '0);
            full_reg        <= (free_count_next == cnt_t'(TAG_COUNT));
        end
    end

    // Frees land at tail (slot 0 first); the read side sees them next cycle
    always_ff @(posedge i_clock) begin
        for (int i = 0; i < TAG_COUNT; i++) begin
            if (i_reset) begin
                list_reg[i] <= tag_lt'(i);
            end else if (free_acc[0] && (wr0_ptr == ptr_t'(i))) begin
                list_reg[i] <= bus.i_free_tag[0];
            end else if (free_acc[1] && (wr1_ptr == ptr_t'(i))) begin
                list_reg[i] <= bus.i_free_tag[1];
            end
        end
    end

`ifdef REN_TAG_POOL_CHECK_EN
    logic [TAG_COUNT-1:0] alloc_map_reg, alloc_map_next;
    logic [TAG_COUNT-1:0] discard;
    logic                 error_reg;
    logic                 acc0, acc1;

    assign acc0     = bus.i_free_valid[0] && alloc_map_reg[bus.i_free_tag[0]];
    assign acc1     = bus.i_free_valid[1] && alloc_map_reg[bus.i_free_tag[1]]
                      && !(acc0 && (bus.i_free_tag[1] == bus.i_free_tag[0]));
    assign free_acc = {acc1, acc0};

    // List positions between the committed head and the speculative head are discarded on flush
    genvar gi;
    generate
        for (gi = 0; gi < TAG_COUNT; gi++) begin : g_discard
            ptr_t off;
            assign off         = ptr_t'(gi) - commit_head_next;
            assign discard[gi] = bus.i_flush && (cnt_t'(off) < uncommitted_left);
        end
    endgenerate

    always_comb begin
        alloc_map_next = alloc_map_reg;
        for (int k = 0; k < TAG_COUNT; k++) begin
            if (discard[k]) alloc_map_next[list_reg[k]] = 1'b0;
        end
        if (acc0) alloc_map_next[bus.i_free_tag[0]] = 1'b0;
        if (acc1) alloc_map_next[bus.i_free_tag[1]] = 1'b0;
        if (n_grant != 2'd0) alloc_map_next[list_reg[spec_head_reg]] = 1'b1;
        if (n_grant == 2'd2) alloc_map_next[list_reg[head_p1]] = 1'b1;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            alloc_map_reg <= '0;
            error_reg     <= 1'b0;
        end else begin
            alloc_map_reg <= alloc_map_next;
            error_reg     <= error_reg | (|(bus.i_free_valid & ~free_acc));
        end
    end

    assign bus.o_error = error_reg;
`else
    assign free_acc = bus.i_free_valid;
`endif
endmodule

// File: tb/tb_ren_tag_pool.sv
// Self-checking bench for ren_tag_pool: vector table, directed corner sequences,
// and randomized legal traffic against a queue-based free-list model.
module tb_ren_tag_pool;
    localparam int TW = pkg_defines::TAG_WIDTH;
    localparam int TC = pkg_defines::TAG_COUNT;

    logic clk;
    logic rst;

    ren_tag_pool_if #(.TAG_WIDTH(TW)) bus ();

    ren_tag_pool #(.TAG_WIDTH(TW), .TAG_COUNT(TC)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] req;
        logic [1:0] cmt;
        logic       fl;
        logic       exp_ok;
        int         exp_t0;
        int         exp_t1;
        int         exp_cap;
        logic       exp_empty;
        logic       exp_full;
    } vec_t;

    localparam int NV = 8;
    vec_t tbl [NV];

    // Model state: free tags in allocation order, uncommitted grants, committed outstanding
    int free_q[$];
    int unc_q[$];
    int com_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] cmt, input logic [1:0] fv,
                         input int t0, input int t1, input logic fl);
        bus.i_alloc_req   = req;
        bus.i_commit      = cmt;
        bus.i_free_valid  = fv;
        bus.i_free_tag[0] = t0[TW-1:0];
        bus.i_free_tag[1] = t1[TW-1:0];
        bus.i_flush       = fl;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic model_reset();
        free_q.delete();
        unc_q.delete();
        com_q.delete();
        for (int i = 0; i < TC; i++) free_q.push_back(i);
    endtask

    initial begin
        tbl[0] = '{2'b00, 2'b00, 1'b0, 1'b1, 0, 1, 2, 1'b0, 1'b1};
        tbl[1] = '{2'b11, 2'b00, 1'b0, 1'b1, 0, 1, 2, 1'b0, 1'b1};
        tbl[2] = '{2'b11, 2'b00, 1'b0, 1'b1, 2, 3, 2, 1'b0, 1'b0};
        tbl[3] = '{2'b11, 2'b00, 1'b0, 1'b1, 4, 5, 2, 1'b0, 1'b0};
        tbl[4] = '{2'b00, 2'b11, 1'b0, 1'b1, 6, 7, 2, 1'b0, 1'b0};
        tbl[5] = '{2'b11, 2'b00, 1'b1, 1'b0, 6, 7, 2, 1'b0, 1'b0};
        tbl[6] = '{2'b01, 2'b00, 1'b0, 1'b1, 2, 3, 2, 1'b0, 1'b0};
        tbl[7] = '{2'b10, 2'b00, 1'b0, 1'b1, 3, 3, 2, 1'b0, 1'b0};

        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0);
        @(negedge clk);

        // Table: reset state, dual allocs, commit, flush, slot-1-only grant
        do_reset();
        for (int v = 0; v < NV; v++) begin
            drive(tbl[v].req, tbl[v].cmt, 2'b00, 0, 0, tbl[v].fl);
            check($sformatf("vec%0d_ok", v), int'(bus.o_alloc_ok), int'(tbl[v].exp_ok));
            check($sformatf("vec%0d_tag0", v), int'(bus.o_alloc_tag[0]), tbl[v].exp_t0);
            check($sformatf("vec%0d_tag1", v), int'(bus.o_alloc_tag[1]), tbl[v].exp_t1);
            check($sformatf("vec%0d_cap", v), int'(bus.o_ren_capacity), tbl[v].exp_cap);
            check($sformatf("vec%0d_empty", v), int'(bus.o_empty), int'(tbl[v].exp_empty));
            check($sformatf("vec%0d_full", v), int'(bus.o_full), int'(tbl[v].exp_full));
            $display("vec %0d req=%b cmt=%b fl=%0d ok=%0d tag0=%0d tag1=%0d", v, tbl[v].req,
                     tbl[v].cmt, tbl[v].fl, bus.o_alloc_ok, bus.o_alloc_tag[0], bus.o_alloc_tag[1]);
            @(negedge clk);
        end
        // After flush 30 were free and 2 were re-granted: exactly 14 dual grants remain
        for (int k = 0; k < 14; k++) begin
            drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
            check("post_flush_ok", int'(bus.o_alloc_ok), 1);
            check("post_flush_tag0", int'(bus.o_alloc_tag[0]), 4 + 2 * k);
            check("post_flush_tag1", int'(bus.o_alloc_tag[1]), 5 + 2 * k);
            @(negedge clk);
        end
        drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0);
        check("post_flush_empty", int'(bus.o_empty), 1);
        check("post_flush_cap", int'(bus.o_ren_capacity), 0);
        $display("seq flush-recovery done");

        // Drain the whole pool with dual requests, then refuse a 17th
        do_reset();
        for (int k = 0; k < 16; k++) begin
            drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
            check("drain_ok", int'(bus.o_alloc_ok), 1);
            check("drain_tag0", int'(bus.o_alloc_tag[0]), 2 * k);
            check("drain_tag1", int'(bus.o_alloc_tag[1]), 2 * k + 1);
            @(negedge clk);
        end
        drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0);
        check("drain_empty", int'(bus.o_empty), 1);
        check("drain_cap", int'(bus.o_ren_capacity), 0);
        drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
        check("drain_17th_ok", int'(bus.o_alloc_ok), 0);
        @(negedge clk);
        $display("seq drain done");

        // Commit all, return 31 tags so the tail sits at index 31, re-drain, then wrap
        for (int k = 0; k < 16; k++) begin
            drive(2'b00, 2'b11, 2'b00, 0, 0, 1'b0);
            @(negedge clk);
        end
        for (int k = 0; k < 15; k++) begin
            drive(2'b00, 2'b00, 2'b11, 2 * k, 2 * k + 1, 1'b0);
            @(negedge clk);
        end
        drive(2'b00, 2'b00, 2'b01, 30, 0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 15; k++) begin
            drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
            check("regrant_tag0", int'(bus.o_alloc_tag[0]), 2 * k);
            check("regrant_tag1", int'(bus.o_alloc_tag[1]), 2 * k + 1);
            @(negedge clk);
        end
        drive(2'b01, 2'b00, 2'b00, 0, 0, 1'b0);
        check("regrant_last", int'(bus.o_alloc_tag[0]), 30);
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            drive(2'b00, (k == 15) ? 2'b01 : 2'b11, 2'b00, 0, 0, 1'b0);
            @(negedge clk);
        end
        drive(2'b11, 2'b00, 2'b11, 7, 9, 1'b0);
        check("wrap_refused", int'(bus.o_alloc_ok), 0);
        check("wrap_empty_before", int'(bus.o_empty), 1);
        @(negedge clk);
        drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
        check("wrap_ok", int'(bus.o_alloc_ok), 1);
        check("wrap_tag0", int'(bus.o_alloc_tag[0]), 7);
        check("wrap_tag1", int'(bus.o_alloc_tag[1]), 9);
        check("wrap_cap", int'(bus.o_ren_capacity), 2);
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0);
        check("wrap_empty_after", int'(bus.o_empty), 1);
        $display("seq tail-wrap done");

        // One free tag: dual request refused, lone slot-1 request gets the head tag
        do_reset();
        for (int k = 0; k < 15; k++) begin
            drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
            @(negedge clk);
        end
        drive(2'b01, 2'b00, 2'b00, 0, 0, 1'b0);
        @(negedge clk);
        drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
        check("one_left_dual_ok", int'(bus.o_alloc_ok), 0);
        check("one_left_cap", int'(bus.o_ren_capacity), 1);
        check("one_left_tag0", int'(bus.o_alloc_tag[0]), 31);
        @(negedge clk);
        drive(2'b10, 2'b00, 2'b00, 0, 0, 1'b0);
        check("one_left_slot1_ok", int'(bus.o_alloc_ok), 1);
        check("one_left_slot1_tag", int'(bus.o_alloc_tag[1]), 31);
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0);
        check("one_left_empty", int'(bus.o_empty), 1);
        $display("seq single-slot done");

`ifdef REN_TAG_POOL_CHECK_EN
        do_reset();
        drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0);
        check("err_after_reset", int'(bus.o_error), 0);
        drive(2'b00, 2'b00, 2'b01, 5, 0, 1'b0);
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0);
        check("err_bad_free", int'(bus.o_error), 1);
        check("err_full_kept", int'(bus.o_full), 1);
        @(negedge clk);
        check("err_sticky", int'(bus.o_error), 1);
        $display("seq ownership-check done");
`endif

        // Randomized legal traffic against the queue model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic [1:0] req, cmt, fv;
            logic       fl, rs, exp_ok;
            int         t0, t1, nc, nf, nreq, idx, lim, ta, tb;
            rs  = ($urandom_range(0, 399) == 0);
            fl  = ($urandom_range(0, 19) == 0);
            req = 2'($urandom_range(0, 3));
            lim = (unc_q.size() < 2) ? unc_q.size() : 2;
            nc  = int'($urandom_range(0, lim));
            cmt = (nc == 2) ? 2'b11 : (nc == 1) ? (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10) : 2'b00;
            lim = (com_q.size() < 2) ? com_q.size() : 2;
            nf  = int'($urandom_range(0, lim));
            fv  = 2'b00;
            t0  = 0;
            t1  = 0;
            if (nf >= 1) begin
                idx = int'($urandom_range(0, com_q.size() - 1));
                ta  = com_q[idx];
                com_q.delete(idx);
                if (nf == 2) begin
                    idx = int'($urandom_range(0, com_q.size() - 1));
                    tb  = com_q[idx];
                    com_q.delete(idx);
                    fv  = 2'b11;
                    t0  = ta;
                    t1  = tb;
                end else if ($urandom_range(0, 1) == 0) begin
                    fv = 2'b01;
                    t0 = ta;
                end else begin
                    fv = 2'b10;
                    t1 = ta;
                end
            end
            rst = rs;
            drive(req, cmt, fv, t0, t1, fl);

            nreq   = int'(req[0]) + int'(req[1]);
            exp_ok = (nreq <= free_q.size()) && !fl;
            check("rnd_cap", int'(bus.o_ren_capacity), (free_q.size() < 2) ? free_q.size() : 2);
            check("rnd_empty", int'(bus.o_empty), int'(free_q.size() == 0));
            check("rnd_full", int'(bus.o_full), int'(free_q.size() == TC));
            check("rnd_ok", int'(bus.o_alloc_ok), int'(exp_ok));
            if (exp_ok && req[0]) check("rnd_tag0", int'(bus.o_alloc_tag[0]), free_q[0]);
            if (exp_ok && req[1])
                check("rnd_tag1", int'(bus.o_alloc_tag[1]), (req == 2'b10) ? free_q[0] : free_q[1]);
            $display("rnd %0d rs=%0d fl=%0d req=%b cmt=%b free=%b ok=%0d cap=%0d", cyc, rs, fl,
                     req, cmt, fv, bus.o_alloc_ok, bus.o_ren_capacity);

            if (rs) begin
                model_reset();
            end else begin
                for (int c = 0; c < nc; c++) com_q.push_back(unc_q.pop_front());
                if (exp_ok) begin
                    for (int a = 0; a < nreq; a++) unc_q.push_back(free_q.pop_front());
                end
                if (fl) begin
                    for (int u = unc_q.size() - 1; u >= 0; u--) free_q.push_front(unc_q[u]);
                    unc_q.delete();
                end
                if (fv[0]) free_q.push_back(t0);
                if (fv[1]) free_q.push_back(t1);
            end
            @(negedge clk);
        end
        rst = 1'b0;
`ifdef REN_TAG_POOL_CHECK_EN
        drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0);
        check("rnd_no_error", int'(bus.o_error), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
